// File: rtl/snn_core_pkg.sv
// Shared packet-geometry helpers for the SNN core: field widths and offsets
// of an axon spike packet (axon number in the upper bits, tick in the lower bits).
package snn_core_pkg;

  function automatic int axon_w(input int num_axons);
    return (num_axons > 1) ? $clog2(num_axons) : 1;
  endfunction

  function automatic int tick_w(input int num_ticks);
    return (num_ticks > 1) ? $clog2(num_ticks) : 1;
  endfunction

  function automatic int pkt_w(input int num_axons, input int num_ticks);
    return axon_w(num_axons) + tick_w(num_ticks);
  endfunction

  function automatic int tick_lsb();
    return 0;
  endfunction

  function automatic int axon_lsb(input int num_ticks);
    return tick_w(num_ticks);
  endfunction

endpackage

// File: rtl/axon_spike_queue_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer moves to the
// port after the granted one only when the caller strobes advance.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;
  logic             found;
  int               idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
        found      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (int'(gidx) == N - 1) ? '0 : PTR_W'(int'(gidx) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axon_spike_queue.sv
// Multi-port axon spike FIFO with round-robin write arbitration, registered read
// and accepted/done packet accounting. Optional hwm port: AXON_SPIKE_QUEUE_HWM_EN.
module axon_spike_queue
  import snn_core_pkg::*;
#(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_TICKS   = 16,
  parameter int NUM_PORTS   = 2,
  parameter int DEPTH       = 128,
  parameter int COUNT_WIDTH = 16,
  localparam int AXON_W     = axon_w(NUM_AXONS),
  localparam int TICK_W     = tick_w(NUM_TICKS),
  localparam int PKT_W      = pkt_w(NUM_AXONS, NUM_TICKS),
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       wr_en,
  input  logic [NUM_PORTS*PKT_W-1:0] wr_packet,
  output logic [NUM_PORTS-1:0]       wr_ready,
  input  logic                       rd_en,
  output logic [AXON_W-1:0]          rd_axon,
  output logic [TICK_W-1:0]          rd_tick,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [LVL_W-1:0]           level,
  input  logic                       done_in,
  output logic                       core_done,
`ifdef AXON_SPIKE_QUEUE_HWM_EN
  output logic [LVL_W-1:0]           hwm,
`endif
  output logic                       error
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int AXON_LSB = axon_lsb(NUM_TICKS);
  localparam int TICK_LSB = tick_lsb();

  logic [PKT_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, done_cnt_q, done_cnt_d, outstanding_d;
  logic                   error_q, error_d, rd_valid_q, rd_valid_d;
  logic [PKT_W-1:0]       rd_pkt_q;
  logic [NUM_PORTS-1:0]   req, grant;
  logic [PKT_W-1:0]       masked_pkt [NUM_PORTS];
  logic [PKT_W-1:0]       wr_pkt;
  logic                   push, pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign req   = wr_en & {NUM_PORTS{~full}};
  assign push  = |grant;
  assign pop   = rd_en & ~empty;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(push),
    .grant  (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign masked_pkt[gi] = grant[gi] ? wr_packet[gi*PKT_W +: PKT_W] : '0;
    end
  endgenerate

  always_comb begin
    wr_pkt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_pkt = wr_pkt | masked_pkt[p];
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_valid_d = pop;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    acc_cnt_d     = push    ? acc_cnt_q + 1'b1  : acc_cnt_q;
    done_cnt_d    = done_in ? done_cnt_q + 1'b1 : done_cnt_q;
    outstanding_d = acc_cnt_d - done_cnt_d;
    // A write in the same cycle covers the done pulse, so it is not an underflow.
    error_d = error_q
            | (done_in && (acc_cnt_q == done_cnt_q) && !push)
            | (push && (outstanding_d == '1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      acc_cnt_q  <= '0;
      done_cnt_q <= '0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      acc_cnt_q  <= acc_cnt_d;
      done_cnt_q <= done_cnt_d;
      error_q    <= error_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array with a registered read port so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pkt_q <= '0;
    end else if (pop) begin
      rd_pkt_q <= mem[rd_ptr_q];
    end
  end

`ifdef AXON_SPIKE_QUEUE_HWM_EN
  logic [LVL_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (level_d > hwm_q) ? level_d : hwm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

  assign wr_ready  = grant;
  assign rd_axon   = rd_pkt_q[AXON_LSB +: AXON_W];
  assign rd_tick   = rd_pkt_q[TICK_LSB +: TICK_W];
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign core_done = (acc_cnt_q == done_cnt_q);
  assign error     = error_q;

endmodule

// File: tb/tb_axon_spike_queue.sv
// Scoreboard bench for axon_spike_queue: directed scenarios plus randomized
// traffic against a queue-based reference model; pops are checked by a monitor.
module tb_axon_spike_queue;

  localparam int N  = 2;
  localparam int PW = 12;
  localparam int D  = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  wr_en;
  logic [N*PW-1:0] wr_packet;
  logic [N-1:0]  wr_ready;
  logic          rd_en;
  logic [7:0]    rd_axon;
  logic [3:0]    rd_tick;
  logic          rd_valid, empty, full, done_in, core_done, error;
  logic [7:0]    level;
`ifdef AXON_SPIKE_QUEUE_HWM_EN
  logic [7:0]    hwm;
  int            m_hwm;
`endif

  always #5 clk = ~clk;

  axon_spike_queue #(
    .NUM_AXONS(256), .NUM_TICKS(16), .NUM_PORTS(N), .DEPTH(D), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_packet(wr_packet), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_axon(rd_axon), .rd_tick(rd_tick), .rd_valid(rd_valid),
    .empty(empty), .full(full), .level(level), .done_in(done_in),
    .core_done(core_done),
`ifdef AXON_SPIKE_QUEUE_HWM_EN
    .hwm(hwm),
`endif
    .error(error)
  );

  // Reference model state
  logic [PW-1:0] m_fifo [$];
  logic [PW-1:0] exp_q  [$];
  int            m_start;
  logic [15:0]   m_acc, m_done;
  logic          m_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_start = 0;
    m_acc   = '0;
    m_done  = '0;
    m_err   = 1'b0;
`ifdef AXON_SPIKE_QUEUE_HWM_EN
    m_hwm   = 0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = '0; wr_packet = '0; rd_en = 1'b0; done_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive, check pre-edge state and grant at negedge, advance the model.
  task automatic step(input logic [N-1:0] en, input logic [N*PW-1:0] pk,
                      input logic rd, input logic dn, output logic [N-1:0] gv);
    int g;
    logic do_pop;
    wr_en = en; wr_packet = pk; rd_en = rd; done_in = dn;
    @(negedge clk);
    g = -1;
    if (m_fifo.size() < D) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_start + k) % N;
        if (g < 0 && en[idx]) g = idx;
      end
    end
    gv = (g >= 0) ? N'(1 << g) : '0;
    check("wr_ready", int'(wr_ready), int'(gv));
    check("level", int'(level), m_fifo.size());
    check("full", int'(full), int'(m_fifo.size() == D));
    check("empty", int'(empty), int'(m_fifo.size() == 0));
    check("core_done", int'(core_done), int'(m_acc == m_done));
    check("error", int'(error), int'(m_err));
`ifdef AXON_SPIKE_QUEUE_HWM_EN
    check("hwm", int'(hwm), m_hwm);
`endif
    do_pop = rd && (m_fifo.size() > 0);
    if (do_pop) exp_q.push_back(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back(pk[g*PW +: PW]);
      m_start = (g + 1) % N;
    end
    if (dn && m_acc == m_done && g < 0) m_err = 1'b1;
    if (g >= 0) m_acc = m_acc + 16'd1;
    if (dn) m_done = m_done + 16'd1;
`ifdef AXON_SPIKE_QUEUE_HWM_EN
    if (m_fifo.size() > m_hwm) m_hwm = m_fifo.size();
`endif
    @(posedge clk); #1;
  endtask

  // Monitor: every rd_valid must match the oldest expected pop.
  initial begin
    logic [PW-1:0] e;
    forever begin
      @(posedge clk); #2;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rd_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] pop axon=%02h tick=%0h expected %03h", rd_axon, rd_tick, e);
          check("rd_axon", int'(rd_axon), int'(e[11:4]));
          check("rd_tick", int'(rd_tick), int'(e[3:0]));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] gv;
    logic [N-1:0] pend;
    logic [PW-1:0] pp [N];
    int wp, rp;

    do_reset();
    check("rd_axon_reset", int'(rd_axon), 0);
    check("rd_tick_reset", int'(rd_tick), 0);
    check("rd_valid_reset", int'(rd_valid), 0);

    // Single packet, popped two cycles later
    step(2'b01, {12'h000, 12'hA53}, 1'b0, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);
    step('0, '0, 1'b1, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);

    // Both ports requesting: grants alternate
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b11, {12'hB00 + 12'(i), 12'hC00 + 12'(i)}, 1'b0, 1'b0, gv);
    for (int i = 0; i < 5; i++) step('0, '0, 1'b1, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);

    // Fill to full, then simultaneous write and read
    do_reset();
    for (int i = 0; i < D; i++) step(2'b01, {12'h000, 12'(i * 7)}, 1'b0, 1'b0, gv);
    step(2'b01, {12'h000, 12'hFEE}, 1'b1, 1'b0, gv);
    step(2'b01, {12'h000, 12'hFEE}, 1'b0, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);

    // Accounting: 5 writes, 5 done pulses, last write and last done together
    do_reset();
    step(2'b01, {12'h0, 12'h111}, 1'b0, 1'b0, gv);
    step(2'b01, {12'h0, 12'h222}, 1'b0, 1'b1, gv);
    step(2'b01, {12'h0, 12'h333}, 1'b0, 1'b1, gv);
    step('0, '0, 1'b0, 1'b1, gv);
    step(2'b01, {12'h0, 12'h444}, 1'b0, 1'b1, gv);
    step(2'b01, {12'h0, 12'h555}, 1'b0, 1'b1, gv);
    step('0, '0, 1'b0, 1'b0, gv);

    // Underflow: error sticks until reset
    step('0, '0, 1'b0, 1'b1, gv);
    step('0, '0, 1'b0, 1'b0, gv);
    step(2'b01, {12'h0, 12'h666}, 1'b1, 1'b0, gv);
    step('0, '0, 1'b1, 1'b0, gv);
    do_reset();
    step('0, '0, 1'b0, 1'b0, gv);

`ifdef AXON_SPIKE_QUEUE_HWM_EN
    do_reset();
    for (int i = 0; i < 10; i++) step(2'b01, {12'h0, 12'(i)}, 1'b0, 1'b0, gv);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1, 1'b0, gv);
    for (int i = 0; i < 2; i++) step(2'b10, {12'(i), 12'h0}, 1'b0, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);
    check("hwm_directed", int'(hwm), 10);
    check("level_directed", int'(level), 8);
`endif

    // Randomized traffic with held requests, three load profiles
    do_reset();
    pend = '0;
    for (int seg = 0; seg < 3; seg++) begin
      wp = (seg == 1) ? 90 : 50;
      rp = (seg == 1) ? 15 : ((seg == 2) ? 80 : 45);
      for (int c = 0; c < 700; c++) begin
        for (int p = 0; p < N; p++) begin
          if (!pend[p] && $urandom_range(99) < wp) begin
            pend[p] = 1'b1;
            pp[p]   = PW'($urandom);
          end
        end
        step(pend, {pp[1], pp[0]}, $urandom_range(99) < rp,
             (m_acc != m_done) && ($urandom_range(99) < 40), gv);
        pend = pend & ~gv;
      end
    end

    // Drain, bounded
    for (int i = 0; i < D + 4 && m_fifo.size() > 0; i++) step('0, '0, 1'b1, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);
    step('0, '0, 1'b0, 1'b0, gv);
    check("drain_model_empty", m_fifo.size(), 0);
    check("outstanding_pops", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axon_spike_queue.md
Name: axon_spike_queue

Overview:
- Parametrised successor to the single-port axon input FIFO in the core.
- Accepts spike packets from NUM_PORTS router-side write channels through round-robin arbitration, buffers them in one DEPTH-entry FIFO, and serves the Controller with a registered read/valid interface.
- Integrates packet accounting: accepted vs. completed counts drive core_done, with a sticky error on overflow or completion underflow.

Parameters:
- NUM_AXONS, 256: axon count; AXON_W = $clog2(NUM_AXONS).
- NUM_TICKS, 16: tick count; TICK_W = $clog2(NUM_TICKS); PKT_W = AXON_W + TICK_W.
- NUM_PORTS, 2: write channels, 1..8.
- DEPTH, 128: FIFO entries, power of two, at least 2.
- COUNT_WIDTH, 16: width of the accepted and done packet counters.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- wr_en, in, NUM_PORTS: per-port write request; held until wr_ready.
- wr_packet, in, NUM_PORTS*PKT_W: port i occupies bits [i*PKT_W +: PKT_W]; axon in the upper AXON_W bits, tick in the lower TICK_W bits.
- wr_ready, out, NUM_PORTS: one-hot-or-zero; high means port i is written this cycle.
- rd_en, in, 1: pop request.
- rd_axon, out, AXON_W: head axon number.
- rd_tick, out, TICK_W: head tick field.
- rd_valid, out, 1: rd_axon/rd_tick valid this cycle.
- empty, out, 1: FIFO empty.
- full, out, 1: FIFO full.
- level, out, $clog2(DEPTH)+1: current occupancy.
- done_in, in, 1: one pulse per packet fully processed (synapse-connection done).
- core_done, out, 1: accepted count equals done count.
- error, out, 1: sticky error flag.
- hwm, out, $clog2(DEPTH)+1: high-water mark; exists only under the optional feature.

Behaviour:
- Reset (synchronous, active-high): pointers, level, counters, error, rd_valid and the round-robin pointer clear. rd_axon and rd_tick reset to 0. core_done reads 1 after reset.
- Arbitration:
  - Round-robin over requesting ports, starting from the port after the last granted port.
  - Grant is combinational. wr_ready[g] = wr_en[g] and not full.
  - At most one write per cycle. The pointer advances only on an actual write.
  - Ungranted ports hold wr_en and wr_packet stable.
- Write while full: no write and no wr_ready; the request stays pending, with no error.
- Read:
  - A pop occurs when rd_en is high and empty is low.
  - Data is registered; rd_valid goes high the next cycle (1-cycle latency).
  - rd_valid is a single-cycle pulse per pop.
  - rd_en while empty is ignored: rd_valid stays 0 and no error is raised.
- Simultaneous write and read:
  - When neither full nor empty, both occur and level is unchanged.
  - When full, only the read occurs; the write is eligible next cycle, with no same-cycle pass-through.
  - When empty, only the write occurs; no bypass, so the earliest rd_valid is 2 cycles after the write.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full and empty derive from level.
- Accounting:
  - acc_cnt increments on each accepted write.
  - done_cnt increments on each done_in pulse.
  - Both are COUNT_WIDTH bits and wrap modulo 2^COUNT_WIDTH.
  - core_done = (acc_cnt == done_cnt), combinational from registers.
  - A same-cycle accepted write and done_in increment both counters.
- error (sticky until rst) sets on:
  - done_in when acc_cnt == done_cnt and no write is accepted in the same cycle (underflow);
  - acc_cnt - done_cnt reaching 2^COUNT_WIDTH - 1 on an accepted write (outstanding-count overflow).
- Reset mid-operation: discards FIFO contents and any pending pop. rd_valid is 0 in the cycle after rst.

Optional Feature:
- Macro: AXON_SPIKE_QUEUE_HWM_EN.
- When defined: port hwm exists. It resets to 0 and updates to the next-cycle level whenever that exceeds hwm, so it tracks the maximum occupancy since reset.
- When undefined: no hwm port or register; all other behaviour is identical.

Decomposition:
- Package snn_core_pkg holds the shared width functions/constants: AXON_W, TICK_W, PKT_W, and the packet field offsets (axon upper, tick lower).
- Sub-module rr_arbiter (parameter N) takes the request vector and advance strobe and returns a one-hot grant. It holds the rotating priority pointer.
- FIFO storage and counters stay in axon_spike_queue.

Test Plan:
- Single port 0, packet 12'hA53 written to empty queue → wr_ready[0] same cycle; rd_en two cycles later → rd_valid the following cycle with rd_axon=8'hA5, rd_tick=4'h3; level goes 0→1→0.
- Ports 0 and 1 both request continuously for 4 cycles → grants alternate 0,1,0,1 (after reset the pointer starts at port 0); the FIFO holds 4 entries in that order.
- Fill to DEPTH=128 with no reads, then assert wr_en and rd_en together → full=1; no wr_ready in the pop cycle; write granted next cycle; level returns to 128.
- 5 accepted writes and 5 done_in pulses, with write 5 and done 5 in the same cycle → core_done low during processing, high after the final cycle; error stays 0.
- done_in with no outstanding packets → error=1 and stays 1 until rst; rst clears error, level and rd_valid, and core_done reads 1.
- With AXON_SPIKE_QUEUE_HWM_EN: write 10, read 4, write 2 → hwm=10 while level=8.
